// File: rtl/amp_i2c_target.sv
// I2C target engine: decodes START/STOP, address, register pointer and data
// bytes, drives ACK/read data open-drain on SDA and issues register bus strobes.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting in 7-bit address + R/W
// ADDR_ACK  | driving address ACK; read fetch issued here
// PTR       | shifting in register pointer
// PTR_ACK   | driving pointer ACK
// WDATA     | shifting in write data byte
// WDATA_ACK | driving data ACK
// RDATA     | presenting read byte MSB first
// RDATA_ACK | sampling master ACK/NACK
// IGNORE    | not addressed or read finished; only START/STOP matter
module amp_i2c_target #(
  parameter logic [6:0] I2C_ADDR    = 7'b0100000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       resetb,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       rw_q;
  logic       sda_oe_q;
  logic [7:0] reg_addr_q, reg_wdata_q;
  logic       wr_en_q, rd_en_q, busy_q;
  logic [7:0] byte_in;
  logic       last_bit;

  // Bus idles high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign byte_in   = {shift_q[6:0], sda_s};
  assign last_bit  = scl_rise && (bit_cnt_q == 4'd7);

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      if (rd_en_q) shift_q <= reg_rdata;
      if (wr_en_q) reg_addr_q <= reg_addr_q + 8'd1;
      if (start_det) begin
        state_q   <= ADDR;
        busy_q    <= 1'b1;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
      end else if (stop_det) begin
        state_q  <= IDLE;
        busy_q   <= 1'b0;
        sda_oe_q <= 1'b0;
      end else begin
        case (state_q)
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              shift_q   <= byte_in;
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            if (last_bit) begin
              bit_cnt_q <= '0;
              if (state_q == ADDR) begin
                if (byte_in[7:1] == I2C_ADDR) begin
                  rw_q    <= byte_in[0];
                  state_q <= ADDR_ACK;
                end else begin
                  state_q <= IGNORE;
                end
              end else if (state_q == PTR) begin
                reg_addr_q <= byte_in;
                state_q    <= PTR_ACK;
              end else begin
                reg_wdata_q <= byte_in;
                wr_en_q     <= 1'b1;
                state_q     <= WDATA_ACK;
              end
            end
          end
          // First fall after bit 8 starts the ACK, the next fall ends it.
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
                if (state_q == ADDR_ACK && rw_q) rd_en_q <= 1'b1;
              end else if (state_q == ADDR_ACK && rw_q) begin
                sda_oe_q <= ~shift_q[7];
                state_q  <= RDATA;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= (state_q == ADDR_ACK) ? PTR : WDATA;
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= RDATA_ACK;
              end else begin
                sda_oe_q <= ~shift_q[6];
                shift_q  <= {shift_q[6:0], 1'b0};
              end
            end
          end
          // bit_cnt_q==1 marks "master ACKed, next byte fetched".
          RDATA_ACK: begin
            if (scl_rise) begin
              reg_addr_q <= reg_addr_q + 8'd1;
              if (!sda_s) begin
                rd_en_q   <= 1'b1;
                bit_cnt_q <= 4'd1;
              end else begin
                state_q <= IGNORE;
              end
            end else if (scl_fall && bit_cnt_q == 4'd1) begin
              sda_oe_q  <= ~shift_q[7];
              bit_cnt_q <= '0;
              state_q   <= RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr_en = wr_en_q;
  assign reg_rd_en = rd_en_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_amp_i2c_target.sv
// Bench for amp_i2c_target: bit-banged I2C master, register-bus device model,
// strobe scoreboard and a byte-level reference model of the target.
module tb_amp_i2c_target;

  localparam int Q = 100;  // quarter SCL period, 10 clk_in cycles

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       resetb;
  logic       m_scl;
  logic       m_sda_low;
  wire        sda_w;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wr_en, reg_rd_en, busy;

  logic [7:0]  bus_mem[256];
  logic [7:0]  ref_mem[256];
  logic [7:0]  ref_ptr;
  logic [15:0] wq[$];
  logic [7:0]  rq[$];
  int          tests = 0;
  int          fails = 0;
  int          dut_low_cnt = 0;

  always #5 clk = ~clk;

  assign sda_w = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_w);
  assign reg_rdata = bus_mem[reg_addr];

  amp_i2c_target #(.I2C_ADDR(7'h20), .SYNC_STAGES(2)) dut (
    .clk_in   (clk),
    .resetb   (resetb),
    .scl      (m_scl),
    .sda      (sda_w),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wr_en(reg_wr_en),
    .reg_rd_en(reg_rd_en),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  function automatic logic [7:0] init_val(input int i);
    if (i == 'h10) return 8'hA5;
    if (i == 'h11) return 8'h3C;
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: register bus device plus strobe scoreboard.
  initial begin
    logic [15:0] we;
    logic [7:0]  re;
    for (int i = 0; i < 256; i++) bus_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (!m_sda_low && sda_w === 1'b0) dut_low_cnt++;
      if (reg_wr_en && reg_rd_en) begin
        tests++; fails++;
        $display("FAIL strobe_excl: wr_en and rd_en both 1 at %0t", $time);
      end
      if (reg_wr_en) begin
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL wr_unexpected: addr %0h data %0h, none expected", reg_addr, reg_wdata);
        end else begin
          we = wq.pop_front();
          check("wr_addr", 32'(reg_addr), 32'(we[15:8]));
          check("wr_data", 32'(reg_wdata), 32'(we[7:0]));
        end
        bus_mem[reg_addr] = reg_wdata;
      end
      if (reg_rd_en) begin
        if (rq.size() == 0) begin
          tests++; fails++;
          $display("FAIL rd_unexpected: addr %0h, none expected", reg_addr);
        end else begin
          re = rq.pop_front();
          check("rd_addr", 32'(reg_addr), 32'(re));
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic i2c_start();
    m_sda_low = 1'b0; #Q;
    m_scl = 1'b1;     #Q;
    m_sda_low = 1'b1; #Q;
    m_scl = 1'b0;     #Q;
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; #Q;
    m_scl = 1'b1;     #Q;
    m_sda_low = 1'b0; #Q;
  endtask

  task automatic put_bit(input logic b);
    m_sda_low = ~b; #Q;
    m_scl = 1'b1;   #(2*Q);
    m_scl = 1'b0;   #Q;
  endtask

  task automatic get_bit(output logic b);
    m_sda_low = 1'b0; #Q;
    m_scl = 1'b1;     #Q;
    b = sda_w;        #Q;
    m_scl = 1'b0;     #Q;
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  task automatic xfer_write(input logic [6:0] a, input logic [7:0] ptr, input bq_t data,
                            input bit stop);
    logic       ack;
    logic       hit;
    logic [7:0] p;
    hit = (a == 7'h20);
    i2c_start();
    check("busy_start", 32'(busy), 32'd1);
    put_byte({a, 1'b0}, ack);
    check("addr_ack", 32'(ack), hit ? 32'd0 : 32'd1);
    put_byte(ptr, ack);
    check("ptr_ack", 32'(ack), hit ? 32'd0 : 32'd1);
    p = ptr;
    foreach (data[i]) begin
      if (hit) begin
        wq.push_back({p, data[i]});
        ref_mem[p] = data[i];
      end
      put_byte(data[i], ack);
      check("data_ack", 32'(ack), hit ? 32'd0 : 32'd1);
      p = p + 8'd1;
    end
    if (hit) ref_ptr = p;
    if (stop) begin
      i2c_stop();
      #Q;
      check("busy_stop", 32'(busy), 32'd0);
    end
  endtask

  task automatic xfer_read(input int n);
    logic       ack;
    logic [7:0] d;
    i2c_start();
    check("busy_rstart", 32'(busy), 32'd1);
    rq.push_back(ref_ptr);
    put_byte({7'h20, 1'b1}, ack);
    check("raddr_ack", 32'(ack), 32'd0);
    for (int i = 0; i < n; i++) begin
      if (i < n - 1) rq.push_back(ref_ptr + 8'd1);
      get_byte(i == n - 1, d);
      check("rd_byte", 32'(d), 32'(ref_mem[ref_ptr]));
      ref_ptr = ref_ptr + 8'd1;
    end
    check("sda_rel_nack", 32'(sda_w), 32'd1);
  endtask

  initial begin
    bq_t        q;
    logic       ack;
    logic [6:0] a;
    logic [7:0] p;
    int         base, n, kind;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    ref_ptr = 8'h00;
    m_scl = 1'b1;
    m_sda_low = 1'b0;
    resetb = 1'b0;
    #(Q);
    resetb = 1'b1;
    #(Q);
    check("rst_sda", 32'(sda_w), 32'd1);
    check("rst_addr", 32'(reg_addr), 32'd0);
    check("rst_wdata", 32'(reg_wdata), 32'd0);
    check("rst_strobes", 32'({reg_wr_en, reg_rd_en}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    q.delete(); q.push_back(8'h18);
    xfer_write(7'h20, 8'h40, q, 1'b1);
    check("addr_after_w1", 32'(reg_addr), 32'(ref_ptr));

    q.delete(); q.push_back(8'h08); q.push_back(8'h09);
    xfer_write(7'h20, 8'h35, q, 1'b1);
    check("addr_after_blk", 32'(reg_addr), 32'h37);

    base = dut_low_cnt;
    q.delete(); q.push_back(8'h66);
    xfer_write(7'h21, 8'h55, q, 1'b0);
    check("nack_busy", 32'(busy), 32'd1);
    check("nack_sda_never_low", 32'(dut_low_cnt - base), 32'd0);
    i2c_stop(); #Q;
    check("nack_busy_stop", 32'(busy), 32'd0);
    check("nack_addr_kept", 32'(reg_addr), 32'h37);

    q.delete();
    xfer_write(7'h20, 8'h10, q, 1'b0);
    xfer_read(2);
    i2c_stop(); #Q;
    check("addr_after_rd", 32'(reg_addr), 32'h12);

    q.delete(); q.push_back(8'h01); q.push_back(8'h02);
    xfer_write(7'h20, 8'hFF, q, 1'b1);
    check("addr_wrap", 32'(reg_addr), 32'h01);

    for (int it = 0; it < 6; it++) begin
      kind = $urandom_range(0, 2);
      p = 8'($urandom);
      n = $urandom_range(1, 3);
      q.delete();
      if (kind == 0) begin
        for (int j = 0; j < n; j++) q.push_back(8'($urandom));
        xfer_write(7'h20, p, q, 1'b1);
      end else if (kind == 1) begin
        xfer_write(7'h20, p, q, 1'b0);
        xfer_read(n);
        i2c_stop(); #Q;
      end else begin
        a = 7'($urandom);
        if (a == 7'h20) a = 7'h21;
        base = dut_low_cnt;
        q.push_back(8'($urandom));
        xfer_write(a, p, q, 1'b1);
        check("rnd_nack_sda", 32'(dut_low_cnt - base), 32'd0);
      end
      check("rnd_addr", 32'(reg_addr), 32'(ref_ptr));
    end

    // Reset while the target drives a 0 data bit.
    q.delete(); q.push_back(8'h00);
    xfer_write(7'h20, 8'h50, q, 1'b1);
    q.delete();
    xfer_write(7'h20, 8'h50, q, 1'b0);
    i2c_start();
    rq.push_back(8'h50);
    put_byte({7'h20, 1'b1}, ack);
    check("rst_rd_ack", 32'(ack), 32'd0);
    m_sda_low = 1'b0; #Q;
    m_scl = 1'b1;     #(Q/2);
    check("rst_bit_low", 32'(sda_w), 32'd0);
    resetb = 1'b0;
    #1;
    check("rst_mid_sda", 32'(sda_w), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_addr", 32'(reg_addr), 32'd0);
    ref_ptr = 8'h00;
    #(Q);
    resetb = 1'b1;
    #(Q);
    m_scl = 1'b0;
    #(Q);
    q.delete(); q.push_back(8'h5A);
    xfer_write(7'h20, 8'h40, q, 1'b1);
    check("post_rst_addr", 32'(reg_addr), 32'h41);

    #(4*Q);
    check("wq_empty", 32'(wq.size()), 32'd0);
    check("rq_empty", 32'(rq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
